// File: rtl/fetch_decode_unit_if.sv
// fetch_decode_unit_if: instruction-memory, branch-redirect and decode-slot signals of the fetch/decode front end.
interface fetch_decode_unit_if #(parameter int ADDR_W = 11, parameter int INSTR_W = 32, parameter int DEPTH = 4);
  logic imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic branch_valid;
  logic [ADDR_W-1:0] branch_address;
  logic dec_valid;
  logic dec_ready;
  logic [INSTR_W-1:0] dec_instr;
  logic [ADDR_W-1:0] dec_pc;
  logic [2:0] dec_opcode;
  logic dec_src_type;
  logic dec_dest_type;
  logic dec_is_mem;
  logic [$clog2(DEPTH):0] fifo_count;
  modport master(
    output imem_req, imem_addr, dec_valid, dec_instr, dec_pc, dec_opcode, dec_src_type, dec_dest_type, dec_is_mem, fifo_count,
    input imem_rdata, branch_valid, branch_address, dec_ready
  );
  modport slave(
    input imem_req, imem_addr, dec_valid, dec_instr, dec_pc, dec_opcode, dec_src_type, dec_dest_type, dec_is_mem, fifo_count,
    output imem_rdata, branch_valid, branch_address, dec_ready
  );
endinterface

// File: rtl/fetch_decode_unit.sv
// fetch_decode_unit: PC/fetch issue, prefetch FIFO and registered decode slot with branch flush.
// FDU_BYPASS_EN: a returning word goes straight into a free decode slot when the FIFO is empty.
module fetch_decode_unit #(
  parameter int ADDR_W = 11,
  parameter int INSTR_W = 32,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic clk,
  input logic reset,
  fetch_decode_unit_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  logic [ADDR_W-1:0] pc, req_pc;
  logic req_q;
  logic [INSTR_W-1:0] fifo_instr [DEPTH];
  logic [ADDR_W-1:0] fifo_pc [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] count;
  logic take, push, pop, byp, load;
  logic [INSTR_W-1:0] load_instr;
  logic [ADDR_W-1:0] load_pc;
  assign take = !bus.dec_valid || bus.dec_ready;
  assign pop = count != '0 && take;
`ifdef FDU_BYPASS_EN
  assign byp = req_q && count == '0 && take;
`else
  assign byp = 1'b0;
`endif
  assign push = req_q && !byp;
  assign load = pop || byp;
  assign load_instr = pop ? fifo_instr[rd_ptr] : bus.imem_rdata;
  assign load_pc = pop ? fifo_pc[rd_ptr] : req_pc;
  // in-flight request reserves a slot, so the FIFO never overflows
  assign bus.imem_req = reset && !bus.branch_valid && (count + (PW+1)'(req_q) < (PW+1)'(DEPTH));
  assign bus.imem_addr = pc;
  assign bus.fifo_count = count;
  always_ff @(posedge clk)
    if (push && !bus.branch_valid) begin
      fifo_instr[wr_ptr] <= bus.imem_rdata;
      fifo_pc[wr_ptr] <= req_pc;
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pc <= RESET_PC;
      req_pc <= '0;
      req_q <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      bus.dec_valid <= 1'b0;
      bus.dec_instr <= '0;
      bus.dec_pc <= '0;
      bus.dec_opcode <= '0;
      bus.dec_src_type <= 1'b0;
      bus.dec_dest_type <= 1'b0;
      bus.dec_is_mem <= 1'b0;
    end else if (bus.branch_valid) begin
      pc <= bus.branch_address;
      req_q <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      bus.dec_valid <= 1'b0;
    end else begin
      req_q <= bus.imem_req;
      req_pc <= pc;
      if (bus.imem_req) pc <= pc + ADDR_W'(1);
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
      if (load) begin
        bus.dec_valid <= 1'b1;
        bus.dec_instr <= load_instr;
        bus.dec_pc <= load_pc;
        bus.dec_opcode <= load_instr[31:29];
        bus.dec_src_type <= load_instr[23];
        bus.dec_dest_type <= load_instr[22];
        bus.dec_is_mem <= load_instr[31:30] == 2'b11;
      end else if (bus.dec_ready) bus.dec_valid <= 1'b0;
    end
endmodule

// File: tb/tb_fetch_decode_unit.sv
// tb_fetch_decode_unit: random and directed stimulus against an in-order address scoreboard of the fetch/decode front end.
module tb_fetch_decode_unit;
  localparam int ADDR_W = 11;
  localparam int INSTR_W = 32;
  localparam int DEPTH = 4;
  localparam logic [ADDR_W-1:0] RESET_PC = '0;
`ifdef FDU_BYPASS_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 3;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  fetch_decode_unit_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH)) bus();
  fetch_decode_unit #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  int cyc, first_req, first_val, vcount, reqs, mode;
  logic [ADDR_W-1:0] q[$];
  logic [ADDR_W-1:0] pc_exp, pend;
  bit inflight, pend_v;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // memory contents as a function of address; mode picks the pattern
  function automatic logic [INSTR_W-1:0] word_of(input logic [ADDR_W-1:0] a);
    logic [31:0] h = 32'(a) * 32'h9E3779B1;
    return mode == 0 ? INSTR_W'(a) : mode == 1 ? INSTR_W'((h & 32'hFFC0_0000) | 32'(a)) : INSTR_W'(a[0] ? 32'h8000_0000 : 32'hE0C0_0000);
  endfunction

  // one clock cycle: entered and left at a falling edge
  task automatic step(input bit bv, input logic [ADDR_W-1:0] ba, input bit rdy);
    logic [INSTR_W-1:0] w;
    int exp_fifo;
    bus.imem_rdata = pend_v ? word_of(pend) : INSTR_W'($urandom);
    bus.branch_valid = bv;
    bus.branch_address = ba;
    bus.dec_ready = rdy;
    #1;
    exp_fifo = q.size() - int'(bus.dec_valid) - int'(inflight);
    chk("fifo_count", bus.fifo_count, exp_fifo);
    chk("imem_req", bus.imem_req, !bv && (exp_fifo + int'(inflight) < DEPTH));
    if (bus.imem_req) begin
      chk("imem_addr", bus.imem_addr, pc_exp);
      reqs++;
      if (first_req < 0) first_req = cyc;
    end
    if (bus.dec_valid) begin
      vcount++;
      if (first_val < 0) first_val = cyc;
      if (q.size() == 0) chk("dec_spurious", bus.dec_valid, 0);
      else begin
        w = word_of(q[0]);
        chk("dec_pc", bus.dec_pc, q[0]);
        chk("dec_instr", bus.dec_instr, w);
        chk("dec_opcode", bus.dec_opcode, w[31:29]);
        chk("dec_src_type", bus.dec_src_type, w[23]);
        chk("dec_dest_type", bus.dec_dest_type, w[22]);
        chk("dec_is_mem", bus.dec_is_mem, w[31:29] >= 3'd6);
        if (rdy) void'(q.pop_front());
      end
    end
    pend = bus.imem_addr;
    pend_v = bus.imem_req;
    if (bv) begin
      q.delete();
      pc_exp = ba;
      inflight = 0;
    end else begin
      if (bus.imem_req) begin
        q.push_back(pc_exp);
        pc_exp = pc_exp + ADDR_W'(1);
      end
      inflight = bus.imem_req;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_dec_valid", bus.dec_valid, 0);
    chk("rst_fifo_count", bus.fifo_count, 0);
    chk("rst_imem_req", bus.imem_req, 0);
    chk("rst_imem_addr", bus.imem_addr, RESET_PC);
    chk("rst_dec_instr", bus.dec_instr, 0);
    chk("rst_dec_pc", bus.dec_pc, 0);
    chk("rst_dec_fields", {bus.dec_opcode, bus.dec_src_type, bus.dec_dest_type, bus.dec_is_mem}, 0);
    bus.branch_valid = 1'b0;
    bus.branch_address = '0;
    bus.dec_ready = 1'b0;
    bus.imem_rdata = '0;
    q.delete();
    pc_exp = RESET_PC;
    inflight = 0;
    pend_v = 0;
    cyc = 0;
    first_req = -1;
    first_val = -1;
    vcount = 0;
    reqs = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    mode = 0;
    #2;
    do_reset();
    repeat (30) step(0, '0, 1);
    chk("latency", first_val - first_req, LAT);
    chk("stream_nogaps", vcount, 30 - first_val);
    do_reset();
    repeat (12) step(0, '0, 0);
    chk("stall_reqs", reqs, DEPTH + 1);
    chk("stall_fifo", bus.fifo_count, DEPTH);
    chk("stall_instr", bus.dec_instr, 0);
    vcount = 0;
    repeat (5) step(0, '0, 1);
    chk("drain_nogaps", vcount, 5);
    repeat (10) step(0, '0, 1);
    mode = 2;
    do_reset();
    for (int i = 0; i < 10 && !bus.dec_valid; i++) step(0, '0, 0);
    chk("dec_timeout", bus.dec_valid, 1);
    chk("load_op", bus.dec_opcode, 3'b111);
    chk("load_types", {bus.dec_src_type, bus.dec_dest_type, bus.dec_is_mem}, 3'b111);
    step(0, '0, 1);
    chk("add_op", bus.dec_opcode, 3'b100);
    chk("add_is_mem", bus.dec_is_mem, 0);
    repeat (10) step(0, '0, 1);
    mode = 1;
    do_reset();
    for (int i = 0; i < 40 && pc_exp != 11'h010; i++) step(0, '0, 1);
    chk("br_reach", pc_exp, 11'h010);
    step(1, 11'h200, 1);
    chk("br_fifo", bus.fifo_count, 0);
    chk("br_valid", bus.dec_valid, 0);
    chk("br_addr", bus.imem_addr, 11'h200);
    repeat (10) step(0, '0, 1);
    step(1, 11'h7FF, 1);
    chk("wrap_pre", bus.imem_addr, 11'h7FF);
    step(0, '0, 1);
    chk("wrap_addr", bus.imem_addr, 0);
    repeat (5) step(0, '0, 1);
    step(1, 11'h123, 0);
    step(1, 11'h456, 1);
    chk("b2b_addr", bus.imem_addr, 11'h456);
    repeat (20) step(0, '0, 1);
    repeat (3000) step($urandom_range(0, 24) == 0, ADDR_W'($urandom), $urandom_range(0, 3) != 0);
    do_reset();
    for (int i = 0; i < 20 && bus.fifo_count != 3; i++) step(0, '0, 0);
    chk("mid_fill", bus.fifo_count, 3);
    #2;
    do_reset();
    repeat (20) step(0, '0, 1);
    chk("restart_first_req", first_req, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
